// File: rtl/tdc_pkg.sv
// Shared types and widths for the TDC measurement controller.
package tdc_pkg;
    localparam int TDC_WORD_W = 12;
    localparam int RESULT_W   = 20;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        ACCUM,
        DONE
    } tdc_state_e;
endpackage

// File: rtl/tdc_ctrl_acc.sv
// Sample accumulator and result register for tdc_ctrl.
// Build option TDC_CTRL_AVG_EN: result is the rounded mean instead of the raw sum.
module tdc_ctrl_acc
    import tdc_pkg::*;
#(
    parameter int LOG2_N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  add,
    input  logic                  load,
    input  logic [TDC_WORD_W-1:0] tdc_word,
    output logic [RESULT_W-1:0]   result
);
`ifdef TDC_CTRL_AVG_EN
    localparam int SHIFT = LOG2_N;
`else
    localparam int SHIFT = 0;
`endif

    logic [RESULT_W-1:0] acc;
    logic [RESULT_W-1:0] sum;
    logic [RESULT_W-1:0] res_d;

    // Result is taken from the sum including the final sample, so it is ready on entry to DONE.
    assign sum = acc + RESULT_W'(tdc_word);

    generate
        if (SHIFT > 0) begin : g_avg
            localparam logic [RESULT_W-1:0] HALF = RESULT_W'(1) << (SHIFT - 1);
            logic [RESULT_W-1:0] rnd;
            // 4095*256 + 128 still fits in 20 bits
            assign rnd   = sum + HALF;
            assign res_d = rnd >> SHIFT;
        end else begin : g_sum
            assign res_d = sum;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (clr)
                acc <= '0;
            else if (add)
                acc <= sum;
            if (load)
                result <= res_d;
        end
    end
endmodule

// File: rtl/tdc_ctrl.sv
// TDC measurement sequencer: clear, settle, accumulate 2^LOG2_N samples, report.
// Build option TDC_CTRL_AVG_EN selects averaged result (see tdc_ctrl_acc).
module tdc_ctrl
    import tdc_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int LOG2_N     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TDC_WORD_W-1:0] tdc_word,
    output logic                  tdc_rst,
    output logic                  tdc_en,
    output logic                  busy,
    output logic                  done,
    output logic [RESULT_W-1:0]   result
);
    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'((1 << LOG2_N) - 1);

    tdc_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             acc_last;

    assign acc_last = (state == ACCUM) && (cnt == ACC_LAST);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE:   if (start) state_nx = CLEAR;
            CLEAR: begin
                state_nx = SETTLE;
                cnt_nx   = '0;
            end
            SETTLE: begin
                if (cnt == SET_LAST) begin
                    state_nx = ACCUM;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ACCUM: begin
                if (cnt == ACC_LAST) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // abort overrides every transition, including start in IDLE
        if (abort) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end
    end

    // tdc_rst/tdc_en registered from next state so they are glitch-free and track the state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            tdc_rst <= 1'b1;
            tdc_en  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            tdc_rst <= (state_nx == CLEAR);
            tdc_en  <= (state_nx == SETTLE) || (state_nx == ACCUM);
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    tdc_ctrl_acc #(
        .LOG2_N (LOG2_N)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      ((state == CLEAR) && !abort),
        .add      ((state == ACCUM) && !abort),
        .load     (acc_last && !abort),
        .tdc_word (tdc_word),
        .result   (result)
    );
endmodule

// File: tb/tb_tdc_ctrl.sv
// Directed bench for tdc_ctrl: default instance plus a LOG2_N=8 instance for the wide-sum case.
module tb_tdc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, start8;
    logic [11:0] tdc_word, word8;
    logic        tdc_rst, tdc_en, busy, done;
    logic        tdc_rst8, tdc_en8, busy8, done8;
    logic [19:0] result, result8;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef TDC_CTRL_AVG_EN
    localparam int EXP_C100 = 100;
    localparam int EXP_RAMP = 8;
    localparam int EXP_C50  = 50;
    localparam int EXP_MAX8 = 4095;
`else
    localparam int EXP_C100 = 1600;
    localparam int EXP_RAMP = 120;
    localparam int EXP_C50  = 800;
    localparam int EXP_MAX8 = 1048320;
`endif

    always #5 clk = ~clk;

    tdc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tdc_word(tdc_word),
        .tdc_rst(tdc_rst), .tdc_en(tdc_en), .busy(busy), .done(done), .result(result)
    );

    tdc_ctrl #(.SETTLE_CYC(4), .LOG2_N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .abort(1'b0), .tdc_word(word8),
        .tdc_rst(tdc_rst8), .tdc_en(tdc_en8), .busy(busy8), .done(done8), .result(result8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; abort = 0; start8 = 0; tdc_word = 0; word8 = 0;
        #12;
        n_chk++; if (tdc_rst !== 1'b1) begin n_fail++; $display("FAIL reset_tdc_rst got %b want 1", tdc_rst); end
        n_chk++; if ({tdc_en, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl got %b want 000", {tdc_en, busy, done}); end
        n_chk++; if (result !== 20'd0) begin n_fail++; $display("FAIL reset_result got %0d want 0", result); end
        step();
        rst_n = 1'b1;
        #1;
        n_chk++; if (tdc_rst !== 1'b1) begin n_fail++; $display("FAIL reset_hold_tdc_rst got %b want 1", tdc_rst); end
        step();
        n_chk++; if (tdc_rst !== 1'b0) begin n_fail++; $display("FAIL reset_release_tdc_rst got %b want 0", tdc_rst); end
    endtask

    task automatic test_const();
        int k;
        tdc_word = 12'd100;
        start = 1; step(); start = 0; k = 1;
        n_chk++; if ({tdc_rst, tdc_en, busy} !== 3'b101) begin n_fail++; $display("FAIL const_clear got %b want 101", {tdc_rst, tdc_en, busy}); end
        step(); k++;
        n_chk++; if ({tdc_rst, tdc_en} !== 2'b01) begin n_fail++; $display("FAIL const_settle got %b want 01", {tdc_rst, tdc_en}); end
        while (!done && k < 40) begin step(); k++; end
        n_chk++; if (k !== 22) begin n_fail++; $display("FAIL const_latency got %0d want 22", k); end
        n_chk++; if (result !== 20'(EXP_C100)) begin n_fail++; $display("FAIL const_result got %0d want %0d", result, EXP_C100); end
        step();
        n_chk++; if ({done, busy, tdc_en} !== 3'b000) begin n_fail++; $display("FAIL const_after got %b want 000", {done, busy, tdc_en}); end
        n_chk++; if (result !== 20'(EXP_C100)) begin n_fail++; $display("FAIL const_hold got %0d want %0d", result, EXP_C100); end
    endtask

    task automatic test_ramp();
        start = 1; step(); start = 0;
        tdc_word = 12'hFFF;                 // settle samples must be discarded
        repeat (5) step();
        for (int i = 0; i < 16; i++) begin
            tdc_word = 12'(i);
            step();
        end
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL ramp_done got %b want 1", done); end
        n_chk++; if (result !== 20'(EXP_RAMP)) begin n_fail++; $display("FAIL ramp_result got %0d want %0d", result, EXP_RAMP); end
        step();
    endtask

    task automatic test_abort();
        int nd = 0;
        tdc_word = 12'd7;
        start = 1; step(); start = 0;
        repeat (7) step();                  // now in 3rd ACCUM cycle
        abort = 1; step(); abort = 0;
        n_chk++; if ({busy, tdc_en, done} !== 3'b000) begin n_fail++; $display("FAIL abort_idle got %b want 000", {busy, tdc_en, done}); end
        repeat (25) begin step(); if (done) nd++; end
        n_chk++; if (nd !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", nd); end
        n_chk++; if (result !== 20'(EXP_RAMP)) begin n_fail++; $display("FAIL abort_result got %0d want %0d", result, EXP_RAMP); end
        start = 1; abort = 1; step(); start = 0; abort = 0;
        n_chk++; if ({busy, tdc_rst} !== 2'b00) begin n_fail++; $display("FAIL start_abort_same got %b want 00", {busy, tdc_rst}); end
    endtask

    task automatic test_back_to_back();
        int nd = 0;
        int k;
        tdc_word = 12'd50;
        start = 1;
        for (int c = 1; c <= 23; c++) begin
            step();
            start = (c == 3 || c == 22);    // pokes in SETTLE and in DONE
            if (done) nd++;
        end
        n_chk++; if (nd !== 1) begin n_fail++; $display("FAIL b2b_done_count got %0d want 1", nd); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_not_queued got %b want 0", busy); end
        n_chk++; if (result !== 20'(EXP_C50)) begin n_fail++; $display("FAIL b2b_result1 got %0d want %0d", result, EXP_C50); end
        tdc_word = 12'd100;
        start = 1; step(); start = 0; k = 1;
        n_chk++; if ({busy, tdc_rst} !== 2'b11) begin n_fail++; $display("FAIL b2b_restart got %b want 11", {busy, tdc_rst}); end
        while (!done && k < 40) begin step(); k++; end
        n_chk++; if (k !== 22) begin n_fail++; $display("FAIL b2b_latency got %0d want 22", k); end
        n_chk++; if (result !== 20'(EXP_C100)) begin n_fail++; $display("FAIL b2b_result2 got %0d want %0d", result, EXP_C100); end
        step();
    endtask

    task automatic test_log2n8();
        int k;
        word8 = 12'd4095;
        start8 = 1; step(); start8 = 0; k = 1;
        while (!done8 && k < 300) begin step(); k++; end
        n_chk++; if (k !== 262) begin n_fail++; $display("FAIL n256_latency got %0d want 262", k); end
        n_chk++; if (result8 !== 20'(EXP_MAX8)) begin n_fail++; $display("FAIL n256_result got %0d want %0d", result8, EXP_MAX8); end
        step();
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        tdc_word = 12'd9;
        start = 1; step(); start = 0;
        repeat (9) step();                  // mid-ACCUM
        rst_n = 1'b0;
        #1;
        n_chk++; if ({tdc_rst, tdc_en, busy, done} !== 4'b1000) begin n_fail++; $display("FAIL midrst_ctl got %b want 1000", {tdc_rst, tdc_en, busy, done}); end
        n_chk++; if (result !== 20'd0) begin n_fail++; $display("FAIL midrst_result got %0d want 0", result); end
        #2;
        rst_n = 1'b1;
        #1;
        n_chk++; if (tdc_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_hold got %b want 1", tdc_rst); end
        step();
        n_chk++; if ({tdc_rst, busy} !== 2'b00) begin n_fail++; $display("FAIL midrst_release got %b want 00", {tdc_rst, busy}); end
        repeat (25) begin step(); if (done) nd++; end
        n_chk++; if (nd !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d want 0", nd); end
    endtask

    initial begin
        test_reset();
        test_const();
        test_ramp();
        test_abort();
        test_back_to_back();
        test_log2n8();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
